pipe_stage_chain: RTL and testbench

Parametrised pipeline backbone that generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB stage buffers of the 5-stage CPU into one configurable chain. It holds STAGES registers of WIDTH bits, each with a valid bit. Per-stage stall requests propagate to all younger stages, and per-stage flush requests insert bubbles. Hazard detection and branch logic drive the chain; datapath stages read its contents.

---
 rtl/pipe_stage_chain.sv | 118 +++++++++++
 tb/tb_pipe_stage_chain.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: STAGES-deep valid/data pipeline with stall propagation toward younger stages and flush-by-kill.
// Optional saturating performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_stage_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 5,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    in_ready,
    input  logic [STAGES-1:0]       stall_req,
    input  logic [STAGES-1:0]       flush_req,
    output logic [STAGES-1:0]       stage_valid,
    output logic [STAGES*WIDTH-1:0] stage_data,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CNT_W-1:0]        stall_cycles,
    output logic [CNT_W-1:0]        flush_count,
    output logic [CNT_W-1:0]        retired_count
);

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] kill;

    // Both hold and kill fan out from older stages to every younger one.
    always_comb begin
        hold = '0;
        kill = '0;
        hold[STAGES-1] = stall_req[STAGES-1];
        kill[STAGES-1] = flush_req[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            hold[i] = stall_req[i] | hold[i+1];
            kill[i] = flush_req[i] | kill[i+1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;
            logic             src_valid;
            logic [WIDTH-1:0] src_data;
            logic             bubble;

            if (gi == 0) begin : g_head
                assign src_valid = in_valid;
                assign src_data  = in_data;
                assign bubble    = 1'b0;
            end else begin : g_body
                assign src_valid = stage_valid[gi-1];
                assign src_data  = stage_data[(gi-1)*WIDTH +: WIDTH];
                assign bubble    = hold[gi-1];
            end

            // Priority: kill, hold, bubble from a held predecessor, then normal advance.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else if (kill[gi]) begin
                    valid_reg <= 1'b0;
                end else if (!hold[gi]) begin
                    if (bubble) begin
                        valid_reg <= 1'b0;
                    end else begin
                        valid_reg <= src_valid;
                        data_reg  <= src_data;
                    end
                end
            end

            assign stage_valid[gi]               = valid_reg;
            assign stage_data[gi*WIDTH +: WIDTH] = data_reg;
        end
    endgenerate

    assign in_ready  = ~hold[0];
    assign out_valid = stage_valid[STAGES-1];
    assign out_data  = stage_data[(STAGES-1)*WIDTH +: WIDTH];

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic             retire;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;
    logic [CNT_W-1:0] retire_cnt_reg;

    assign retire = stage_valid[STAGES-1] & ~kill[STAGES-1] & ~hold[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg  <= '0;
            flush_cnt_reg  <= '0;
            retire_cnt_reg <= '0;
        end else begin
            if (hold[0] && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
            if ((|flush_req) && (flush_cnt_reg != '1))
                flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
            if (retire && (retire_cnt_reg != '1))
                retire_cnt_reg <= retire_cnt_reg + CNT_ONE;
        end
    end

    assign stall_cycles  = stall_cnt_reg;
    assign flush_count   = flush_cnt_reg;
    assign retired_count = retire_cnt_reg;
`else
    assign stall_cycles  = '0;
    assign flush_count   = '0;
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed testbench for pipe_stage_chain (WIDTH=8, STAGES=5, CNT_W=4); counter expectations follow PIPE_PERF_CNT_EN.
module tb_pipe_stage_chain;

    localparam int W = 8;
    localparam int S = 5;
    localparam int C = 4;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic           in_ready;
    logic [S-1:0]   stall_req = '0;
    logic [S-1:0]   flush_req = '0;
    logic [S-1:0]   stage_valid;
    logic [S*W-1:0] stage_data;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [C-1:0]   stall_cycles;
    logic [C-1:0]   flush_count;
    logic [C-1:0]   retired_count;

    int vectors = 0;
    int miscompares = 0;

    pipe_stage_chain #(.WIDTH(W), .STAGES(S), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .stall_req(stall_req), .flush_req(flush_req), .stage_valid(stage_valid),
        .stage_data(stage_data), .out_valid(out_valid), .out_data(out_data),
        .stall_cycles(stall_cycles), .flush_count(flush_count), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] sd(input int i);
        return stage_data[i*W +: W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        stall_req = '0;
        flush_req = '0;
        rst       = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
    endtask

    // Drives base+0 .. base+4 on five consecutive edges, leaving the pipe full.
    task automatic fill(input logic [W-1:0] base);
        in_valid = 1'b1;
        for (int k = 0; k < S; k++) begin
            in_data = base + W'(k);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        vectors++;
        if (stage_valid !== '0 || stage_data !== '0 || out_valid !== 1'b0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL reset_state got valid=%b data=%h out=%b/%h exp all zero", stage_valid, stage_data, out_valid, out_data);
        end
        vectors++;
        if (stall_cycles !== '0 || flush_count !== '0 || retired_count !== '0) begin
            miscompares++;
            $display("FAIL reset_counters got %h %h %h exp 0 0 0", stall_cycles, flush_count, retired_count);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
        $display("[reset] valid=%b in_ready=%b", stage_valid, in_ready);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_d;
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'h01;
        for (int n = 1; n <= 13; n++) begin
            tick();
            $display("[stream] edge %0d out_valid=%b out_data=%h", n, out_valid, out_data);
            vectors++;
            if (out_valid !== ((n >= 5 && n <= 12) ? 1'b1 : 1'b0)) begin
                miscompares++;
                $display("FAIL stream_valid edge %0d got %b", n, out_valid);
            end
            if (n >= 5 && n <= 12) begin
                exp_d = W'(n - 4);
                vectors++;
                if (out_data !== exp_d) begin
                    miscompares++;
                    $display("FAIL stream_data edge %0d got %h exp %h", n, out_data, exp_d);
                end
            end
            if (n < 8) in_data = W'(n + 1);
            else in_valid = 1'b0;
        end
        vectors++;
        if (retired_count !== (PERF ? 4'd8 : 4'd0)) begin
            miscompares++;
            $display("FAIL stream_retired got %0d exp %0d", retired_count, PERF ? 8 : 0);
        end
    endtask

    task automatic test_stall();
        logic [S-1:0] exp_v [6];
        logic [W-1:0] exp_o [6];
        exp_v = '{5'b10111, 5'b00111, 5'b01110, 5'b11100, 5'b11000, 5'b10000};
        exp_o = '{8'hA1, 8'hA1, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        do_reset();
        fill(8'hA0);
        in_valid  = 1'b1;
        in_data   = 8'hB0;
        stall_req = 5'b00100;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_in_ready got %b exp 0", in_ready);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 1) begin
                stall_req = '0;
                in_valid  = 1'b0;
            end
            $display("[stall] edge %0d valid=%b out_data=%h", c + 6, stage_valid, out_data);
            vectors++;
            if (stage_valid !== exp_v[c] || out_data !== exp_o[c]) begin
                miscompares++;
                $display("FAIL stall_seq edge %0d got %b/%h exp %b/%h", c + 6, stage_valid, out_data, exp_v[c], exp_o[c]);
            end
            if (c < 2) begin
                vectors++;
                if (sd(0) !== 8'hA4 || sd(1) !== 8'hA3 || sd(2) !== 8'hA2) begin
                    miscompares++;
                    $display("FAIL stall_frozen edge %0d got %h %h %h exp a4 a3 a2", c + 6, sd(0), sd(1), sd(2));
                end
            end
            if (c == 1) begin
                #1;
                vectors++;
                if (in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall_release_ready got %b exp 1", in_ready);
                end
            end
        end
        vectors++;
        if (stall_cycles !== (PERF ? 4'd2 : 4'd0) || retired_count !== (PERF ? 4'd4 : 4'd0)) begin
            miscompares++;
            $display("FAIL stall_counters got stall=%0d retired=%0d", stall_cycles, retired_count);
        end
    endtask

    task automatic test_stall_flush();
        do_reset();
        fill(8'hC0);
        stall_req = 5'b01000;
        flush_req = 5'b00010;
        tick();
        stall_req = '0;
        flush_req = '0;
        $display("[stall_flush] valid=%b data=%h", stage_valid, stage_data);
        vectors++;
        if (stage_valid !== 5'b01100) begin
            miscompares++;
            $display("FAIL sf_valid got %b exp 01100", stage_valid);
        end
        vectors++;
        if (sd(0) !== 8'hC4 || sd(1) !== 8'hC3 || sd(2) !== 8'hC2 || sd(3) !== 8'hC1 || sd(4) !== 8'hC0) begin
            miscompares++;
            $display("FAIL sf_data got %h exp c0c1c2c3c4", stage_data);
        end
    endtask

    task automatic test_flush_all();
        do_reset();
        fill(8'hD0);
        flush_req = 5'b10000;
        tick();
        flush_req = '0;
        vectors++;
        if (stage_valid !== '0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_valid got %b/%b exp 00000/0", stage_valid, out_valid);
        end
        vectors++;
        if (flush_count !== (PERF ? 4'd1 : 4'd0)) begin
            miscompares++;
            $display("FAIL flush_count got %0d exp %0d", flush_count, PERF ? 1 : 0);
        end
        in_valid = 1'b1;
        in_data  = 8'hE0;
        for (int n = 7; n <= 11; n++) begin
            tick();
            in_valid = 1'b0;
            $display("[flush] edge %0d out_valid=%b out_data=%h", n, out_valid, out_data);
            vectors++;
            if (out_valid !== (n == 11) || (n == 11 && out_data !== 8'hE0)) begin
                miscompares++;
                $display("FAIL flush_refill edge %0d got %b/%h exp %b/e0", n, out_valid, out_data, n == 11);
            end
        end
        vectors++;
        if (retired_count !== '0) begin
            miscompares++;
            $display("FAIL flush_retired got %0d exp 0", retired_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        in_valid = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            in_data = W'(8'h10 + n);
            tick();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        $display("[async_reset] valid=%b out_data=%h", stage_valid, out_data);
        vectors++;
        if (stage_valid !== '0 || out_data !== '0 || stage_data !== '0) begin
            miscompares++;
            $display("FAIL async_reset got valid=%b out=%h data=%h exp zeros", stage_valid, out_data, stage_data);
        end
        #2 rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int n = 1; n <= 5; n++) begin
            tick();
            in_data = 8'h78;
            if (n == 1) in_valid = 1'b1;
            vectors++;
            if (out_valid !== (n == 5) || (n == 5 && out_data !== 8'h77)) begin
                miscompares++;
                $display("FAIL async_restart edge %0d got %b/%h exp %b/77", n, out_valid, out_data, n == 5);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        stall_req = 5'b00001;
        for (int n = 0; n < 20; n++) tick();
        $display("[saturate] stall_cycles=%0d in_ready=%b", stall_cycles, in_ready);
        vectors++;
        if (stall_cycles !== (PERF ? 4'd15 : 4'd0)) begin
            miscompares++;
            $display("FAIL saturate got %0d exp %0d", stall_cycles, PERF ? 15 : 0);
        end
        vectors++;
        if (in_ready !== 1'b0 || flush_count !== '0 || retired_count !== '0) begin
            miscompares++;
            $display("FAIL saturate_side got ready=%b flush=%0d retired=%0d exp 0 0 0", in_ready, flush_count, retired_count);
        end
        stall_req = '0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_stall_flush();
        test_flush_all();
        test_async_reset();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
